// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// The loader uses the slave view; the byte source/memory side uses master.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian word image into instruction memory and
// holds the core in reset until it completes. Optional trailer: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned MAX_WORDS = 1 << (ADDR_W - 2);
  localparam int unsigned WCNT_W    = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_TAIL = S_CHK;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         len_q, len_d;
  logic [23:0]         asm_q, asm_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif
  logic                accept_c;
  logic [15:0]         len_new_c;

  assign accept_c  = bus.in_valid && in_ready_q;
  assign len_new_c = {len_hi_q, bus.in_data};

  // State and datapath register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      asm_q       <= 24'd0;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= WCNT_W'(0);
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_W'(0);
      mem_wdata_q <= 32'd0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      asm_q       <= asm_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    asm_d       = asm_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          byte_cnt_d = 2'd0;
          word_cnt_d = WCNT_W'(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = 8'd0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept_c) begin
          len_hi_d = bus.in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept_c) begin
          len_d = len_new_c;
          if (17'(len_new_c) > 17'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else if (len_new_c == 16'd0) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept_c) begin
          asm_d      = {asm_q[15:0], bus.in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ bus.in_data;
`endif
          // Fourth byte completes a word: write it next cycle
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {asm_q, bus.in_data};
            mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'({word_cnt_q, 2'b00});
            word_cnt_d  = word_cnt_q + WCNT_W'(1);
            if (16'(word_cnt_q) + 16'd1 == len_q) begin
              state_d = S_TAIL;
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_c) begin
          state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
    in_ready_d  = busy_d;
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    // Release the core only once DONE has been held for a cycle, so the final
    // write is never concurrent with cpu_reset low.
    cpu_reset_d = !((state_q == S_DONE) && (state_d == S_DONE));
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes,
// an independent monitor pops and compares them on every mem_we.
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned BASE_ADDR = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  int   last_acc_edge = -10;
  wr_t  exp_q[$];
  logic [31:0] img [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must be expected, in order, one edge after a byte accept
  always @(negedge clk) begin
    if (reset && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h", bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("write_data", bus.mem_wdata, e.data);
        check("write_latency", 32'(edge_cnt - last_acc_edge), 32'd0);
        check("cpu_reset_during_write", 32'(cpu_reset), 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) last_acc_edge = edge_cnt;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte %h not accepted", b);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hFF;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_in_ready", 32'(bus.in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clear", 32'(done), 32'd0);
    check("start_err_clear", 32'(err), 32'd0);
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
  endtask

  task automatic send_image(input logic [15:0] n, input bit gap, input bit bad_chk);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    for (int i = 0; i < int'(n); i++) begin
      w = img[i];
      exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + 4 * i), data: w});
      for (int j = 3; j >= 0; j--) begin
        x = x ^ w[j*8 +: 8];
        send_byte(w[j*8 +: 8], gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? 8'h00 : x, gap);
`else
    if (bad_chk) x = 8'h00;
`endif
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || err) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done=%b err=%b", name, done, err);
    end
    repeat (3) @(negedge clk);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({name, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({name, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({name, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic check_final(input string name, input bit ok);
    check({name, "_done"}, 32'(done), 32'(ok));
    check({name, "_err"}, 32'(err), 32'(!ok));
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    img[0] = 32'h201E0005;
    img[1] = 32'hAFDE0000;
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;

    // Idle after reset: core held, nothing accepted, no writes
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold", {30'd0, bus.in_ready, cpu_reset}, 32'b01);
    end

    // Back-to-back two-word image
    @(posedge clk); #1;
    do_start();
    send_image(16'd2, 1'b0, 1'b0);
    wait_end("b2b");
    check_final("b2b", 1'b1);

    // Same image with in_valid toggling every cycle
    @(posedge clk); #1;
    do_start();
    send_image(16'd2, 1'b1, 1'b0);
    wait_end("gap");
    check_final("gap", 1'b1);

    // Oversized count 0x0101 > 256
    @(posedge clk); #1;
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("oversize_err_now", 32'(err), 32'd1);
    wait_end("oversize");
    check_final("oversize", 1'b0);

    // Empty image
    @(posedge clk); #1;
    do_start();
    send_image(16'd0, 1'b0, 1'b0);
    wait_end("empty");
    check_final("empty", 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: words still written, then error
    @(posedge clk); #1;
    do_start();
    send_image(16'd2, 1'b0, 1'b1);
    wait_end("badchk");
    check_final("badchk", 1'b0);
`endif

    // Reset after the 5th data byte
    @(posedge clk); #1;
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    exp_q.push_back('{addr: ADDR_W'(BASE_ADDR), data: img[0]});
    for (int j = 3; j >= 0; j--) send_byte(img[0][j*8 +: 8], 1'b0);
    send_byte(img[1][31:24], 1'b0);
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    check("midreset_first_word_written", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    do_start();
    send_image(16'd2, 1'b0, 1'b0);
    wait_end("reload");
    check_final("reload", 1'b1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
